// File: rtl/conv_pkg.sv
// conv_pkg: scheduler state encoding, default layer geometry and width helpers
// Shared by the window counter and the layer scheduler.
package conv_pkg;

  localparam int SIZE_D      = 7;
  localparam int SIZEKER_D   = 3;
  localparam int WIDTH_BIT_D = 8;
  localparam int NFILT_D     = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    FINISH
  } state_t;

  // Accumulator width of a k x k window of wb-bit products
  function automatic int accw(input int wb, input int k);
    return 2 * wb + $clog2(k * k);
  endfunction

  // Index width that stays legal for a single-entry range
  function automatic int idxw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/win_counter.sv
// win_counter: nested col/row/filt window index counter, col fastest
// Ports: clock, reset, clear, advance in; row, col, filt, last out.
module win_counter
  import conv_pkg::*;
#(
  parameter int OUT   = 5,
  parameter int NFILT = 4,
  localparam int RW   = idxw(OUT),
  localparam int FW   = idxw(NFILT)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [RW-1:0] row,
  output logic [RW-1:0] col,
  output logic [FW-1:0] filt,
  output logic          last
);

  localparam logic [RW-1:0] CMAX = RW'(OUT - 1);
  localparam logic [FW-1:0] FMAX = FW'(NFILT - 1);

  logic col_end;
  logic row_end;
  logic filt_end;

  assign col_end  = (col == CMAX);
  assign row_end  = (row == CMAX);
  assign filt_end = (filt == FMAX);
  assign last     = col_end && row_end && filt_end;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      row  <= '0;
      col  <= '0;
      filt <= '0;
    end else if (advance) begin
      if (!col_end) begin
        col <= col + RW'(1);
      end else begin
        col <= '0;
        if (!row_end) begin
          row <= row + RW'(1);
        end else begin
          row  <= '0;
          filt <= filt_end ? '0 : filt + FW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv_layer_sched.sv
// conv_layer_sched: issues every window of every filter to a shared MAC engine,
// applies bias + clamp activation, hands results out over valid/ready.
// Ports: clock/reset, start/busy/done, win_* issue, mac_* return, bias,
// out_* result handshake, err_spurious sticky flag.
module conv_layer_sched
  import conv_pkg::*;
#(
  parameter int SIZE      = SIZE_D,
  parameter int SIZEKER   = SIZEKER_D,
  parameter int WIDTH_BIT = WIDTH_BIT_D,
  parameter int NFILT     = NFILT_D,
  localparam int OUT      = SIZE - SIZEKER + 1,
  localparam int ACCW     = accw(WIDTH_BIT, SIZEKER),
  localparam int RW       = idxw(OUT),
  localparam int FW       = idxw(NFILT)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        win_valid,
  output logic [RW-1:0]               win_row,
  output logic [RW-1:0]               win_col,
  output logic [FW-1:0]               filt_idx,
  input  logic                        mac_valid,
  input  logic signed [ACCW-1:0]      mac_result,
  input  logic [NFILT*WIDTH_BIT-1:0]  bias,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [RW-1:0]               out_row,
  output logic [RW-1:0]               out_col,
  output logic [FW-1:0]               out_filt,
  output logic signed [WIDTH_BIT-1:0] out_data,
  output logic                        err_spurious
);

  // One extra bit so the bias add can never overflow
  localparam int SW = ACCW + 1;
  localparam logic signed [SW-1:0] MAXV = SW'((1 << (WIDTH_BIT - 1)) - 1);

  state_t state;

  logic [RW-1:0] row;
  logic [RW-1:0] col;
  logic [FW-1:0] filt;
  logic          last;
  logic          clear;
  logic          advance;

  logic signed [WIDTH_BIT-1:0] bias_sel;
  logic signed [SW-1:0]        sum;
  logic signed [WIDTH_BIT-1:0] act;

  assign clear   = (state == IDLE) && start;
  assign advance = (state == WRITE) && out_ready;

  win_counter #(
    .OUT   (OUT),
    .NFILT (NFILT)
  ) u_cnt (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .advance (advance),
    .row     (row),
    .col     (col),
    .filt    (filt),
    .last    (last)
  );

  assign win_row  = row;
  assign win_col  = col;
  assign filt_idx = filt;

  always_comb begin
    bias_sel = '0;
    for (int i = 0; i < NFILT; i++) begin
      if (filt == FW'(i)) begin
        bias_sel = bias[i*WIDTH_BIT +: WIDTH_BIT];
      end
    end
  end

  assign sum = {mac_result[ACCW-1], mac_result}
             + {{(SW-WIDTH_BIT){bias_sel[WIDTH_BIT-1]}}, bias_sel};

  always_comb begin
    act = sum[WIDTH_BIT-1:0];
    if (sum[SW-1]) begin
      act = '0;
    end else if (sum > MAXV) begin
      act = MAXV[WIDTH_BIT-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      win_valid    <= 1'b0;
      out_valid    <= 1'b0;
      err_spurious <= 1'b0;
      out_data     <= '0;
      out_row      <= '0;
      out_col      <= '0;
      out_filt     <= '0;
    end else begin
      done      <= 1'b0;
      win_valid <= 1'b0;
      if (mac_valid && (state != WAIT)) begin
        err_spurious <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= ISSUE;
            busy         <= 1'b1;
            win_valid    <= 1'b1;
            // a stray result in this very cycle still counts
            err_spurious <= mac_valid;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (mac_valid) begin
            state     <= WRITE;
            out_valid <= 1'b1;
            out_data  <= act;
            out_row   <= row;
            out_col   <= col;
            out_filt  <= filt;
          end
        end
        WRITE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last) begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= ISSUE;
              win_valid <= 1'b1;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// tb_conv_layer_sched: randomized engine/consumer around conv_layer_sched
// with an in-bench ordered result model and directed corner passes.
module tb_conv_layer_sched;

  localparam int SIZE = 7;
  localparam int K    = 3;
  localparam int W    = 8;
  localparam int NF   = 4;
  localparam int O    = SIZE - K + 1;
  localparam int ACCW = 2 * W + $clog2(K * K);
  localparam int RW   = $clog2(O);
  localparam int FW   = $clog2(NF);
  localparam int TOT  = O * O * NF;
  localparam int MAXV = (1 << (W - 1)) - 1;

  logic clock = 1'b0;
  logic reset, start, busy, done, win_valid, mac_valid;
  logic out_valid, out_ready, err_spurious;
  logic [RW-1:0] win_row, win_col, out_row, out_col;
  logic [FW-1:0] filt_idx, out_filt;
  logic signed [ACCW-1:0] mac_result;
  logic [NF*W-1:0] bias;
  logic signed [W-1:0] out_data;

  typedef struct {
    int r;
    int c;
    int f;
    int d;
  } res_t;

  res_t q[$];
  int n_vec = 0;
  int n_mis = 0;
  int wi, nacc, done_cnt;
  bit mon_en = 0;
  bit lit_en = 0;
  int lit_exp[3];
  int tab_mac[3];
  int tab_b[3];

  always #5 clock = ~clock;

  conv_layer_sched #(
    .SIZE      (SIZE),
    .SIZEKER   (K),
    .WIDTH_BIT (W),
    .NFILT     (NF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .win_valid    (win_valid),
    .win_row      (win_row),
    .win_col      (win_col),
    .filt_idx     (filt_idx),
    .mac_valid    (mac_valid),
    .mac_result   (mac_result),
    .bias         (bias),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_row      (out_row),
    .out_col      (out_col),
    .out_filt     (out_filt),
    .out_data     (out_data),
    .err_spurious (err_spurious)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int activ(input int s);
    return (s < 0) ? 0 : ((s > MAXV) ? MAXV : s);
  endfunction

  // compare process
  logic pov, prdy;
  logic signed [W-1:0] hd;
  logic [RW-1:0] hr, hc;
  logic [FW-1:0] hf;
  res_t e;

  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      wi  = 0;
      pov = 1'b0;
    end else if (mon_en) begin
      if (win_valid) begin
        chk("win_row", win_row, (wi / O) % O);
        chk("win_col", win_col, wi % O);
        chk("win_filt", filt_idx, wi / (O * O));
        chk("win_busy", busy, 1);
        chk("win_while_out", out_valid, 0);
        wi++;
      end
      if (out_valid) begin
        if (pov && !prdy) begin
          chk("hold_data", out_data, hd);
          chk("hold_row", out_row, hr);
          chk("hold_col", out_col, hc);
          chk("hold_filt", out_filt, hf);
        end
        if (out_ready) begin
          if (q.size() == 0) begin
            chk("out_queue", q.size(), 1);
          end else begin
            e = q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_row", out_row, e.r);
            chk("out_col", out_col, e.c);
            chk("out_filt", out_filt, e.f);
            if (lit_en && nacc < 3) chk("lit_data", out_data, lit_exp[nacc]);
          end
          nacc++;
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_wins", wi, TOT);
        chk("done_q", q.size(), 0);
        chk("done_busy", busy, 0);
        chk("done_err", err_spurious, 0);
      end
      pov  = out_valid;
      prdy = out_ready;
      hd   = out_data;
      hr   = out_row;
      hc   = out_col;
      hf   = out_filt;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_winv"}, win_valid, 0);
    chk({tag, "_outv"}, out_valid, 0);
    chk({tag, "_err"}, err_spurious, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_wrow"}, win_row, 0);
    chk({tag, "_wcol"}, win_col, 0);
    chk({tag, "_wfilt"}, filt_idx, 0);
    chk({tag, "_orow"}, out_row, 0);
    chk({tag, "_ocol"}, out_col, 0);
    chk({tag, "_ofilt"}, out_filt, 0);
  endtask

  // modes: 0 plain, 1 activation table, 2 stall, 3 reset at window 37,
  // 4 start re-pulsed, 5 random
  task automatic run_pass(input int mode, output int cyc_done);
    int pend, di, stall, m, v, f;
    bit got, rst_next;
    logic signed [W-1:0] b[NF];
    pend = 0; di = 0; stall = 0; m = mode; got = 0; rst_next = 0;
    cyc_done = -1;
    wi = 0; nacc = 0; done_cnt = 0;
    for (int i = 0; i < NF; i++) b[i] = '0;
    bias = '0; mac_valid = 0; out_ready = 1;
    start = 1;
    @(posedge clock); #1;
    start = 0;
    for (int cyc = 1; cyc <= 6000; cyc++) begin
      if (cyc == 1) begin
        chk("start_err_clr", err_spurious, 0);
        chk("start_busy", busy, 1);
      end
      if (done) begin
        cyc_done = cyc;
        got = 1;
        break;
      end
      start = 0;
      mac_valid = 0;
      if (rst_next) begin
        rst_next = 0;
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        chk_zero("midreset");
        pend = 0; di = 0; m = 0;
        start = 1;
        @(posedge clock); #1;
        continue;
      end
      if (m == 4 && (cyc == 50 || cyc == 150)) start = 1;
      if (m == 5) for (int i = 0; i < NF; i++) b[i] = W'($urandom);
      if (win_valid) begin
        if (m == 3 && di == 37) rst_next = 1;
        pend = (m == 5) ? int'($urandom_range(1, 3)) : 1;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          f = di / (O * O);
          if (m == 1 && di < 3) begin
            v = tab_mac[di];
            b[0] = W'(tab_b[di]);
          end else if (m == 5) begin
            v = int'($urandom_range(0, 900)) - 450;
          end else begin
            v = 10;
          end
          mac_valid = 1;
          mac_result = v[ACCW-1:0];
          q.push_back('{(di / O) % O, di % O, f, activ(v + int'(b[f]))});
          di++;
        end
      end
      for (int i = 0; i < NF; i++) bias[i*W +: W] = b[i];
      if (m == 2) begin
        if (out_valid && stall < 5) begin
          out_ready = 0;
          stall++;
        end else begin
          out_ready = 1;
        end
      end else if (m == 5) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1;
      end
      @(posedge clock); #1;
    end
    chk("pass_done_seen", got, 1);
    mac_valid = 0;
    start = 0;
    out_ready = 1;
    @(negedge clock);
    @(posedge clock); #1;
  endtask

  int c;

  initial begin
    reset = 1; start = 0; mac_valid = 0; mac_result = '0;
    bias = '0; out_ready = 1;
    lit_exp = '{0, 127, 127};
    tab_mac = '{-5, 200, 120};
    tab_b   = '{3, 0, 7};
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    chk_zero("reset");
    mon_en = 1;

    run_pass(0, c);
    chk("pass_cycles_plain", c, 301);

    lit_en = 1;
    run_pass(1, c);
    lit_en = 0;
    chk("pass_cycles_table", c, 301);

    run_pass(2, c);
    chk("pass_cycles_stall", c, 306);

    run_pass(3, c);
    chk("restart_done_cnt", done_cnt, 1);

    mac_valid = 1;
    mac_result = ACCW'(55);
    @(posedge clock); #1;
    mac_valid = 0;
    chk("spur_err", err_spurious, 1);
    chk("spur_outv", out_valid, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("spur_err_sticky", err_spurious, 1);
    chk("spur_outv_late", out_valid, 0);

    run_pass(4, c);
    chk("pass_cycles_restart", c, 301);
    repeat (5) @(posedge clock);
    #1;
    chk("single_done", done_cnt, 1);
    chk("idle_busy", busy, 0);

    for (int p = 0; p < 4; p++) begin
      run_pass(5, c);
      chk("rand_done_cnt", done_cnt, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
